rx_vc_framer: RTL and testbench
===============================

# rx_vc_framer

Parametrised endpoint receive framer that delimits packets on a flit stream carrying up to NUM_VC interleaved virtual channels. It keeps an independent framing state and flit counter per VC, tags each forwarded flit with start/end-of-packet and error flags, and drives a one-deep registered valid/ready output stage. It sits between the switch-facing receive port and the endpoint's CRC checker and request decoder. Unlike the single-channel receive FSM, it supports multiple VCs, length bounds checking, backpressure and flush.

## Interface
- FLIT_WIDTH, 32: flit width in bits.
- NUM_VC, 2: number of virtual channels, ≥1; VC_WIDTH = max(1, $clog2(NUM_VC)).
- LEN_WIDTH, 8: width of the header length field and per-VC counters.
- LEN_LSB, 16: LSB position of the length field in a header flit; field is in_flit[LEN_LSB +: LEN_WIDTH].
- MIN_LEN, 2: smallest legal packet length in flits: header plus CRC flit.
- MAX_LEN, 2**LEN_WIDTH-1: largest legal packet length in flits.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous clear of all VC framing state and of the output stage.
- in_valid  in  1  input flit valid.
- in_ready  out  1  block can accept a flit this cycle.
- in_flit  in  FLIT_WIDTH  input flit.
- in_vc  in  VC_WIDTH  VC of the input flit.
- out_valid  out  1  output flit valid.
- out_ready  in  1  downstream accepts the output flit.
- out_flit  out  FLIT_WIDTH  registered copy of the accepted flit.
- out_vc  out  VC_WIDTH  VC of out_flit.
- out_sop  out  1  out_flit is a packet header.
- out_eop  out  1  out_flit is the last flit of its packet (the CRC flit, or an errored header).
- out_err  out  1  header length is out of range.
- vc_busy  out  NUM_VC  bit v set while VC v is mid-packet.
- err_cnt  out  8  saturating count of length errors.

## Operation
- Per-VC state: IDLE or BODY, plus remaining[LEN_WIDTH].
- Accept when in_valid && in_ready. in_ready = !out_valid || out_ready. in_ready is combinational on out_ready and does not depend on in_valid.
- An in_vc value ≥ NUM_VC is treated as length error: the flit is forwarded with out_err=1, sop=1, eop=1, and no VC state changes.
- Accepted flit on an IDLE VC is a header. Let L = length field.
  - If MIN_LEN ≤ L ≤ MAX_LEN: sop=1, eop=0, err=0, remaining=L-1, VC→BODY.
  - Otherwise: sop=1, eop=1, err=1, VC stays IDLE, err_cnt++ (saturates at 255).
- Accepted flit on a BODY VC: sop=0, err=0.
  - If remaining==1: eop=1, remaining=0, VC→IDLE.
  - Else: eop=0, remaining-1.
- Flits of different VCs may interleave arbitrarily. Each VC is framed independently.
- vc_busy[v] = (state[v]==BODY), taken directly from registers.
- flush: all VCs→IDLE, remaining=0, out_valid=0. err_cnt is held. flush takes precedence over a simultaneous accept; that flit is consumed and dropped.
- rst: same as flush, plus err_cnt=0.

## Timing
- Reset values: out_valid=0, out_flit=0, out_vc=0, out_sop=0, out_eop=0, out_err=0, vc_busy=0, err_cnt=0; in_ready=1 after reset.
- Latency: a flit accepted at edge N appears on the outputs after edge N, i.e. in cycle N+1.
- Throughput: one flit per cycle while out_ready=1.
- Output holds stable while out_valid && !out_ready.
- VC state updates at the accepting edge, so a header and its first body flit may arrive back-to-back.
- Once out_valid=1 it stays high until the flit is taken (out_ready=1) or a flush or reset occurs.
- Width rule: L is compared unsigned. remaining never underflows: the eop path only fires at remaining==1.

## Test plan
- Single VC, header L=4, then 3 body flits back-to-back, out_ready=1: out_sop on flit 0 and out_eop on flit 3; vc_busy[0] is 1 for cycles 1–3 after header acceptance.
- Interleaving: VC0 header L=3, VC1 header L=2, VC1 CRC, VC0 body, VC0 CRC: eop only on VC1's 3rd flit and VC0's 5th flit; vc_busy returns to 0.
- Length errors: headers with L=1, L=0 and L=MAX_LEN+1 (when MAX_LEN is configured below 255) → out_err=sop=eop=1 each time, err_cnt=3, VC stays IDLE.
- Backpressure: out_ready=0 for 4 cycles mid-packet → in_ready=0, outputs held; on release, no flit is lost or duplicated and the counts are correct.
- Flush mid-packet (VC0 remaining=5) together with in_valid → out_valid=0 next cycle, vc_busy=0, and the next VC0 flit is decoded as a header.
- Reset mid-packet with err_cnt=7 → all outputs at reset values after the edge, err_cnt=0.

Source files
------------

// File: rtl/rx_vc_framer.sv
// Multi-VC receive framer: per-VC header/body tracking with length bounds checking,
// feeding a one-deep registered valid/ready output stage.
module rx_vc_framer #(
    parameter int unsigned FLIT_WIDTH = 32,
    parameter int unsigned NUM_VC     = 2,
    parameter int unsigned LEN_WIDTH  = 8,
    parameter int unsigned LEN_LSB    = 16,
    parameter int unsigned MIN_LEN    = 2,
    parameter int unsigned MAX_LEN    = (2 ** LEN_WIDTH) - 1,
    localparam int unsigned VC_WIDTH  = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [FLIT_WIDTH-1:0] in_flit_i,
    input  logic [VC_WIDTH-1:0]   in_vc_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [FLIT_WIDTH-1:0] out_flit_o,
    output logic [VC_WIDTH-1:0]   out_vc_o,
    output logic                  out_sop_o,
    output logic                  out_eop_o,
    output logic                  out_err_o,
    output logic [NUM_VC-1:0]     vc_busy_o,
    output logic [7:0]            err_cnt_o
);

    typedef enum logic [0:0] {StIdle, StBody} vc_state_e;

    vc_state_e            state_q [NUM_VC];
    vc_state_e            state_d [NUM_VC];
    logic [LEN_WIDTH-1:0] rem_q   [NUM_VC];
    logic [LEN_WIDTH-1:0] rem_d   [NUM_VC];

    logic                  out_valid_q;
    logic [FLIT_WIDTH-1:0] out_flit_q;
    logic [VC_WIDTH-1:0]   out_vc_q;
    logic                  out_sop_q, out_eop_q, out_err_q;
    logic [7:0]            err_cnt_q, err_cnt_d;

    logic                  accept;
    logic                  vc_ok;
    logic [LEN_WIDTH-1:0]  len;
    logic                  len_ok;
    vc_state_e             cur_state;
    logic [LEN_WIDTH-1:0]  cur_rem;
    logic                  sop_d, eop_d, err_d;

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign vc_ok      = ({1'b0, in_vc_i} < (VC_WIDTH + 1)'(NUM_VC));
    assign len        = in_flit_i[LEN_LSB +: LEN_WIDTH];
    assign len_ok     = (32'(len) >= MIN_LEN) && (32'(len) <= MAX_LEN);

    // Select the addressed VC by comparison so an out-of-range in_vc never indexes the arrays.
    always_comb begin
        cur_state = StIdle;
        cur_rem   = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            if (vc_ok && (VC_WIDTH'(v) == in_vc_i)) begin
                cur_state = state_q[v];
                cur_rem   = rem_q[v];
            end
        end
    end

    always_comb begin
        sop_d = 1'b0;
        eop_d = 1'b0;
        err_d = 1'b0;
        for (int v = 0; v < NUM_VC; v++) begin
            state_d[v] = state_q[v];
            rem_d[v]   = rem_q[v];
        end

        if (!vc_ok) begin
            sop_d = 1'b1;
            eop_d = 1'b1;
            err_d = 1'b1;
        end else if (cur_state == StIdle) begin
            sop_d = 1'b1;
            if (!len_ok) begin
                eop_d = 1'b1;
                err_d = 1'b1;
            end else if (len == LEN_WIDTH'(1)) begin
                // Single-flit packet (only legal when MIN_LEN is 1): never enter BODY with 0 left.
                eop_d = 1'b1;
            end
        end else begin
            eop_d = (cur_rem <= LEN_WIDTH'(1));
        end

        for (int v = 0; v < NUM_VC; v++) begin
            if (accept && vc_ok && (VC_WIDTH'(v) == in_vc_i)) begin
                if (state_q[v] == StIdle) begin
                    if (len_ok && !eop_d) begin
                        state_d[v] = StBody;
                        rem_d[v]   = len - LEN_WIDTH'(1);
                    end
                end else if (eop_d) begin
                    state_d[v] = StIdle;
                    rem_d[v]   = '0;
                end else begin
                    rem_d[v] = rem_q[v] - LEN_WIDTH'(1);
                end
            end
        end

        err_cnt_d = err_cnt_q;
        if (accept && err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= StIdle;
                rem_q[v]   <= '0;
            end
            out_valid_q <= 1'b0;
            out_flit_q  <= '0;
            out_vc_q    <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= 8'd0;
        end else if (flush_i) begin
            // A flit accepted alongside flush is consumed and dropped.
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= StIdle;
                rem_q[v]   <= '0;
            end
            out_valid_q <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                state_q[v] <= state_d[v];
                rem_q[v]   <= rem_d[v];
            end
            err_cnt_q <= err_cnt_d;
            if (accept) begin
                out_valid_q <= 1'b1;
                out_flit_q  <= in_flit_i;
                out_vc_q    <= in_vc_i;
                out_sop_q   <= sop_d;
                out_eop_q   <= eop_d;
                out_err_q   <= err_d;
            end else if (out_ready_i) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    always_comb begin
        for (int v = 0; v < NUM_VC; v++) begin
            vc_busy_o[v] = (state_q[v] == StBody);
        end
    end

    assign out_valid_o = out_valid_q;
    assign out_flit_o  = out_flit_q;
    assign out_vc_o    = out_vc_q;
    assign out_sop_o   = out_sop_q;
    assign out_eop_o   = out_eop_q;
    assign out_err_o   = out_err_q;
    assign err_cnt_o   = err_cnt_q;

endmodule

// File: tb/tb_rx_vc_framer.sv
// Directed bench for rx_vc_framer: framing, interleaving, length errors, backpressure,
// flush and reset, with hand-computed expectations.
module tb_rx_vc_framer;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_flit, out_flit;
    logic        in_vc, out_vc, out_sop, out_eop, out_err;
    logic [1:0]  vc_busy;
    logic [7:0]  err_cnt;

    int checks = 0;
    int errors = 0;

    rx_vc_framer #(
        .FLIT_WIDTH (32),
        .NUM_VC     (2),
        .LEN_WIDTH  (8),
        .LEN_LSB    (16),
        .MIN_LEN    (2),
        .MAX_LEN    (200)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_flit_i   (in_flit),
        .in_vc_i     (in_vc),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_flit_o  (out_flit),
        .out_vc_o    (out_vc),
        .out_sop_o   (out_sop),
        .out_eop_o   (out_eop),
        .out_err_o   (out_err),
        .vc_busy_o   (vc_busy),
        .err_cnt_o   (err_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic v, input logic [31:0] f,
                             input logic vc, input logic s, input logic e, input logic er,
                             input logic [1:0] busy);
        check({tag, ".valid"}, 64'(out_valid), 64'(v));
        check({tag, ".flit"}, 64'(out_flit), 64'(f));
        check({tag, ".vc"}, 64'(out_vc), 64'(vc));
        check({tag, ".sop"}, 64'(out_sop), 64'(s));
        check({tag, ".eop"}, 64'(out_eop), 64'(e));
        check({tag, ".err"}, 64'(out_err), 64'(er));
        check({tag, ".busy"}, 64'(vc_busy), 64'(busy));
    endtask

    task automatic send(input logic [31:0] f, input logic vc);
        in_valid = 1'b1;
        in_flit  = f;
        in_vc    = vc;
        tick();
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_flit = '0; in_vc = 1'b0; out_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        check_out("reset", 0, 32'h0, 0, 0, 0, 0, 2'b00);
        check("reset.err_cnt", 64'(err_cnt), 64'd0);
        check("reset.in_ready", 64'(in_ready), 64'd1);

        // Single VC, L=4, back-to-back body flits.
        send(32'hAA04_0001, 0); check_out("t1.hdr", 1, 32'hAA04_0001, 0, 1, 0, 0, 2'b01);
        send(32'h1111_1111, 0); check_out("t1.b1", 1, 32'h1111_1111, 0, 0, 0, 0, 2'b01);
        send(32'h2222_2222, 0); check_out("t1.b2", 1, 32'h2222_2222, 0, 0, 0, 0, 2'b01);
        send(32'h3333_3333, 0); check_out("t1.crc", 1, 32'h3333_3333, 0, 0, 1, 0, 2'b00);
        in_valid = 1'b0;
        tick();
        check("t1.drain", 64'(out_valid), 64'd0);

        // Interleaved VCs: VC0 L=3, VC1 L=2.
        send(32'h0003_0010, 0); check_out("t2.f1", 1, 32'h0003_0010, 0, 1, 0, 0, 2'b01);
        send(32'h0002_0020, 1); check_out("t2.f2", 1, 32'h0002_0020, 1, 1, 0, 0, 2'b11);
        send(32'h0000_0021, 1); check_out("t2.f3", 1, 32'h0000_0021, 1, 0, 1, 0, 2'b01);
        send(32'h0000_0011, 0); check_out("t2.f4", 1, 32'h0000_0011, 0, 0, 0, 0, 2'b01);
        send(32'h0000_0012, 0); check_out("t2.f5", 1, 32'h0000_0012, 0, 0, 1, 0, 2'b00);

        // Length errors: L=1, L=0, L=MAX_LEN+1 (201).
        send(32'h0001_0030, 0); check_out("t3.l1", 1, 32'h0001_0030, 0, 1, 1, 1, 2'b00);
        check("t3.cnt1", 64'(err_cnt), 64'd1);
        send(32'h0000_0031, 0); check_out("t3.l0", 1, 32'h0000_0031, 0, 1, 1, 1, 2'b00);
        check("t3.cnt2", 64'(err_cnt), 64'd2);
        send(32'h00C9_0032, 0); check_out("t3.l201", 1, 32'h00C9_0032, 0, 1, 1, 1, 2'b00);
        check("t3.cnt3", 64'(err_cnt), 64'd3);
        send(32'h00C8_0033, 1); check_out("t3.l200ok", 1, 32'h00C8_0033, 1, 1, 0, 0, 2'b10);
        rst = 1'b1; in_valid = 1'b0;
        tick();
        rst = 1'b0;
        check("t3.rst_cnt", 64'(err_cnt), 64'd0);
        send(32'h0001_0034, 0);
        send(32'h0000_0035, 0);
        send(32'h00C9_0036, 0);
        check("t3.recount", 64'(err_cnt), 64'd3);

        // Backpressure mid-packet.
        send(32'h0004_0040, 0); check_out("t4.hdr", 1, 32'h0004_0040, 0, 1, 0, 0, 2'b01);
        out_ready = 1'b0;
        in_flit   = 32'h0000_0041;
        #1;
        check("t4.rdy_low", 64'(in_ready), 64'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_out("t4.hold", 1, 32'h0004_0040, 0, 1, 0, 0, 2'b01);
            check("t4.in_ready", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        #1;
        check("t4.rdy_back", 64'(in_ready), 64'd1);
        send(32'h0000_0041, 0); check_out("t4.b1", 1, 32'h0000_0041, 0, 0, 0, 0, 2'b01);
        send(32'h0000_0042, 0); check_out("t4.b2", 1, 32'h0000_0042, 0, 0, 0, 0, 2'b01);
        send(32'h0000_0043, 0); check_out("t4.crc", 1, 32'h0000_0043, 0, 0, 1, 0, 2'b00);
        check("t4.cnt", 64'(err_cnt), 64'd3);

        // Flush with a flit present while VC0 has 5 flits left.
        send(32'h0006_0050, 0); check_out("t5.hdr", 1, 32'h0006_0050, 0, 1, 0, 0, 2'b01);
        flush = 1'b1;
        send(32'h0000_0051, 0);
        flush = 1'b0;
        check("t5.valid", 64'(out_valid), 64'd0);
        check("t5.busy", 64'(vc_busy), 64'd0);
        check("t5.cnt_held", 64'(err_cnt), 64'd3);
        send(32'h0003_0052, 0); check_out("t5.newhdr", 1, 32'h0003_0052, 0, 1, 0, 0, 2'b01);

        // Build err_cnt to 7 on VC1 while VC0 stays mid-packet, then reset.
        for (int i = 0; i < 4; i++) send(32'h0000_0060, 1);
        check("t6.cnt7", 64'(err_cnt), 64'd7);
        check("t6.busy", 64'(vc_busy), 64'b01);
        rst = 1'b1;
        send(32'h0000_0061, 0);
        rst = 1'b0; in_valid = 1'b0;
        check_out("t6.reset", 0, 32'h0, 0, 0, 0, 0, 2'b00);
        check("t6.err_cnt", 64'(err_cnt), 64'd0);
        check("t6.in_ready", 64'(in_ready), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
